// File: rtl/button_debounce.sv
// button_debounce
//   Conditions raw push-button pins for the control logic. Each channel runs
//   a 2-flop synchroniser, a stable-time debounce FSM, and long-press timing,
//   and emits a debounced level plus 1-cycle press / release / long pulses.
//   Channels are fully independent.
//
// Ports
//   clk          system clock (100 MHz)
//   reset        synchronous, active-high reset
//   btn_in       raw asynchronous button pins, 1 = pressed
//   btn_level    debounced level, 1 = pressed
//   btn_press    1-cycle pulse when a press is accepted
//   btn_release  1-cycle pulse when a release is accepted
//   btn_long     1-cycle pulse when a held press reaches LONG_CYC
//   btn_any      OR of btn_level

module button_debounce_lane #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int LONG_CYC     = 64,
  parameter int CNT_W        = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel,
  output logic lng
);

  typedef enum logic [2:0] {
    IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LONG_CYC - 1);

  logic [1:0]       sync;
  logic             s;
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             long_done, long_done_nxt;
  logic             press_c, rel_c, long_c;
  logic             press_q, rel_q, long_q;

  assign s = sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= '0;
      state     <= IDLE;
      cnt       <= '0;
      long_done <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      lng       <= 1'b0;
    end else begin
      sync      <= {sync[0], pin};
      state     <= nxt;
      cnt       <= cnt_nxt;
      long_done <= long_done_nxt;
      press_q   <= press_c;
      rel_q     <= rel_c;
      long_q    <= long_c;
      // Output stage: every output leaves straight from a flop, one cycle
      // behind the FSM decision.
      level     <= (state == PRESSED) || (state == LONG_HELD) ||
                   (state == RELEASE_WAIT);
      press     <= press_q;
      rel       <= rel_q;
      lng       <= long_q;
    end
  end

  always_comb begin
    nxt           = state;
    cnt_nxt       = cnt;
    long_done_nxt = long_done;
    press_c       = 1'b0;
    rel_c         = 1'b0;
    long_c        = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (s) begin
          nxt     = PRESS_WAIT;
          cnt_nxt = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end else if (cnt == D_LAST) begin
          nxt           = PRESSED;
          cnt_nxt       = '0;
          press_c       = 1'b1;
          long_done_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          nxt     = RELEASE_WAIT;
          cnt_nxt = CNT_W'(1);
        end else if (cnt == L_LAST) begin
          nxt           = LONG_HELD;
          cnt_nxt       = '0;
          long_c        = 1'b1;
          long_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        cnt_nxt = '0;
        if (!s) begin
          nxt     = RELEASE_WAIT;
          cnt_nxt = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          // A release glitch after the long pulse must not re-arm it.
          nxt     = long_done ? LONG_HELD : PRESSED;
          cnt_nxt = '0;
        end else if (cnt == D_LAST) begin
          nxt     = IDLE;
          cnt_nxt = '0;
          rel_c   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

endmodule

module button_debounce #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int LONG_CYC     = 64,
  parameter int CNT_W        = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             btn_any
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    button_debounce_lane #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .CNT_W        (CNT_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .pin   (btn_in[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i]),
      .lng   (btn_long[i])
    );
  end

  assign btn_any = |btn_level;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
//   Table-driven exact-edge vectors, hand-written bounce / release-glitch
//   sequences, and randomized pin activity, all checked every cycle against
//   a run-length reference model of the debounce rules.

module tb_button_debounce;
  localparam int N = 4;
  localparam int D = 16;
  localparam int L = 64;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;
  logic         btn_any;

  always #5 clk = ~clk;

  button_debounce #(.N_BTN(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .CNT_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .btn_any     (btn_any)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts consecutive equal samples of the synchronised
  // pin per channel; decisions made on an edge appear on the outputs one
  // edge later.
  logic [N-1:0] m_d1, m_d2;
  int           run1 [N];
  int           run0 [N];
  int           hold [N];
  bit           lvl  [N];
  bit           ldone[N];
  logic [N-1:0] pend_p, pend_r, pend_l;
  logic [N-1:0] e_lvl, e_p, e_r, e_l;

  task automatic model_edge(input logic rst, input logic [N-1:0] pin);
    logic [N-1:0] smp;
    if (rst) begin
      m_d1 = '0; m_d2 = '0;
      pend_p = '0; pend_r = '0; pend_l = '0;
      e_lvl = '0; e_p = '0; e_r = '0; e_l = '0;
      for (int c = 0; c < N; c++) begin
        run1[c] = 0; run0[c] = 0; hold[c] = 0; lvl[c] = 0; ldone[c] = 0;
      end
      return;
    end
    e_p = pend_p; e_r = pend_r; e_l = pend_l;
    for (int c = 0; c < N; c++) e_lvl[c] = lvl[c];
    smp  = m_d2;
    m_d2 = m_d1;
    m_d1 = pin;
    pend_p = '0; pend_r = '0; pend_l = '0;
    for (int c = 0; c < N; c++) begin
      if (!lvl[c]) begin
        if (smp[c]) begin
          run1[c]++;
          if (run1[c] == D) begin
            lvl[c] = 1; pend_p[c] = 1'b1;
            run1[c] = 0; run0[c] = 0; hold[c] = 0; ldone[c] = 0;
          end
        end else run1[c] = 0;
      end else begin
        if (!smp[c]) begin
          run0[c]++;
          hold[c] = 0;
          if (run0[c] == D) begin
            lvl[c] = 0; pend_r[c] = 1'b1; run0[c] = 0; run1[c] = 0;
          end
        end else if (run0[c] > 0) begin
          run0[c] = 0;   // returning sample restarts long timing from zero
          hold[c] = 0;
        end else begin
          hold[c]++;
          if (hold[c] == L && !ldone[c]) begin
            pend_l[c] = 1'b1; ldone[c] = 1;
          end
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] pin);
    @(negedge clk);
    reset  = rst;
    btn_in = pin;
    @(posedge clk);
    model_edge(rst, pin);
    #1;
    chk("model", {15'd0, btn_any, btn_long, btn_release, btn_press, btn_level},
        {15'd0, |e_lvl, e_l, e_r, e_p, e_lvl});
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    int           cyc;
    logic [N-1:0] lvl, prs, rel, lng;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int           bounce_press, rel_cnt, lvl_drop;
    int           rem[N];
    logic [N-1:0] cur;

    // {rst, btn, cycles, expected level, press, release, long after last edge}
    tbl[0]  = '{1'b1, 4'b0000,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0001, 18, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0001,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, 4'b0001, 62, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{1'b0, 4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    tbl[6]  = '{1'b0, 4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b0, 4'b0000, 18, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b0, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[9]  = '{1'b0, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{1'b0, 4'b1111, 19, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    tbl[11] = '{1'b1, 4'b1111,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[12] = '{1'b0, 4'b1111, 18, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[13] = '{1'b0, 4'b1111,  1, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    tbl[14] = '{1'b0, 4'b0000, 19, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    tbl[15] = '{1'b0, 4'b0010,  5, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[16] = '{1'b0, 4'b0000, 25, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < tbl[i].cyc; k++) step(tbl[i].rst, tbl[i].btn);
      chk($sformatf("vec%0d", i),
          {15'd0, btn_any, btn_long, btn_release, btn_press, btn_level},
          {15'd0, |tbl[i].lvl, tbl[i].lng, tbl[i].rel, tbl[i].prs, tbl[i].lvl});
    end

    // Bounce on channel 1: 3 high / 3 low for 30 cycles, then stable high.
    bounce_press = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, (((k / 3) % 2) == 0) ? 4'b0010 : 4'b0000);
      if (btn_press[1] || btn_level[1]) bounce_press++;
    end
    chk("bounce_quiet", bounce_press, 0);
    for (int k = 0; k < 18; k++) begin
      step(1'b0, 4'b0010);
      if (btn_press[1]) bounce_press++;
    end
    chk("bounce_early", bounce_press, 0);
    step(1'b0, 4'b0010);
    chk("bounce_press", btn_press, 4'b0010);
    step(1'b0, 4'b0010);
    chk("bounce_pulse_end", btn_press, 4'b0000);

    // Release glitch on channel 3 while pressed.
    for (int k = 0; k < 20; k++) step(1'b0, 4'b1010);
    chk("glitch_pressed", btn_level[3], 1'b1);
    rel_cnt = 0; lvl_drop = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b0010);
      if (btn_release[3]) rel_cnt++;
      if (!btn_level[3]) lvl_drop++;
    end
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 4'b1010);
      if (btn_release[3]) rel_cnt++;
      if (!btn_level[3]) lvl_drop++;
    end
    chk("glitch_no_release", rel_cnt, 0);
    chk("glitch_level_held", lvl_drop, 0);
    for (int k = 0; k < 25; k++) step(1'b0, 4'b0000);
    chk("all_released", {btn_any, btn_level}, 5'b0);

    // Randomized runs per channel: mostly long holds, some short glitches.
    cur = '0;
    for (int c = 0; c < N; c++) rem[c] = 1;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          cur[c] = ~cur[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                               : int'($urandom_range(10, 90));
        end
      end
      step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side counterpart to the LED output path: conditions raw push-button inputs for the top-level design.
- Per channel: 2-flop synchroniser, stable-time debounce, then a small FSM that emits a debounced level plus single-cycle press, release and long-press pulses.
- Sits between board pins and control logic inside top. Runs on the 100 MHz system clock.

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYC, 16, consecutive stable synchronised samples needed to accept a level change (minimum 2; boards use 1000000 for 10 ms).
- LONG_CYC, 64, cycles held after the press pulse before the long-press pulse fires (minimum 1).
- CNT_W, 24, counter width; must hold max(DEBOUNCE_CYC, LONG_CYC).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  N_BTN  raw asynchronous button pins, 1 = pressed.
- btn_level  output  N_BTN  debounced level, 1 = pressed.
- btn_press  output  N_BTN  1-cycle pulse when a press is accepted.
- btn_release  output  N_BTN  1-cycle pulse when a release is accepted.
- btn_long  output  N_BTN  1-cycle pulse when a held press reaches LONG_CYC.
- btn_any  output  1  OR of btn_level.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on the port reset. Every register updates only on the rising edge of clk.
- Reset state:
  - Sync flops = 0.
  - Counters = 0.
  - Every FSM in IDLE.
  - All outputs = 0.
- Synchroniser: btn_in passes through 2 flops to give s[i]. No logic sits before the second flop.
- Per-channel FSM states:
  - IDLE: released, level 0.
  - PRESS_WAIT
  - PRESSED: level 1.
  - LONG_HELD: level 1.
  - RELEASE_WAIT: level 1.
- IDLE:
  - s=1 → PRESS_WAIT, cnt=1.
  - s=0 → stay.
- PRESS_WAIT:
  - s=0 → IDLE, cnt=0 (glitch rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYC-1 → PRESSED, cnt=0, btn_press and btn_level registered high.
  - Otherwise cnt+1.
- PRESSED:
  - s=0 → RELEASE_WAIT, cnt=1; long counter discarded.
  - s=1 and cnt==LONG_CYC-1 → LONG_HELD, btn_long pulses.
  - Otherwise cnt+1.
- LONG_HELD:
  - s=0 → RELEASE_WAIT, cnt=1.
  - Otherwise stay.
  - btn_long never repeats within one press.
- RELEASE_WAIT:
  - s=1 → back to PRESSED, cnt=0. Long timing restarts; no extra pulses.
  - s=0 and cnt==DEBOUNCE_CYC-1 → IDLE, btn_release pulses, btn_level registered low.
  - Otherwise cnt+1.
- Latency: first edge sampling btn_in=1 is edge 0. btn_press and btn_level are high after edge DEBOUNCE_CYC+2. Release latency is identical.
- btn_long is high after edge DEBOUNCE_CYC+2+LONG_CYC, provided s stays 1 throughout.
- Pulses are exactly 1 cycle wide. btn_press and btn_release are never high in the same cycle on one channel.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses; nothing is serialised.
- btn_any is combinational OR of the registered btn_level.
- Reset mid-operation with the button held: all state clears. After reset deasserts, the held button is re-debounced from IDLE and produces a fresh btn_press with normal latency.
- Counters never wrap: every count terminates at DEBOUNCE_CYC-1 or LONG_CYC-1.

Test Plan:
- Clean press, DEBOUNCE_CYC=16, LONG_CYC=64: btn_in[0] 0→1 at edge 0, held 40 cycles → btn_press[0] high for exactly the cycle after edge 18, btn_level[0]=1 from then, btn_long[0] stays 0.
- Bounce: btn_in[1] toggles every 3 cycles for 30 cycles, then stable 1 → no pulse during bounce; single btn_press[1] exactly 18 edges after the last 0→1.
- Long press then release: btn_in[2] held 100 cycles, then 0 → btn_long[2] one pulse after edge 82; btn_release[2] one pulse 18 edges after the drop; btn_level[2] returns to 0.
- Release glitch: while PRESSED, btn_in[3] drops for 5 cycles, then returns to 1 → no btn_release; btn_level[3] stays 1.
- Simultaneous channels: btn_in=4'b1111 at the same edge → btn_press=4'b1111 in a single cycle; btn_any=1.
- Reset mid-press: assert reset 1 cycle while btn_in[0]=1 in PRESSED → all outputs 0 the next cycle; new btn_press[0] 18 edges after reset deasserts.
